// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding, word size
// and the address legality rule used when a request is accepted.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // A word access is illegal when misaligned or when it lands past the last stored word.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(depth));
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between the core (master) and the data memory (slave).
interface mem_bus_if;
    // Each channel transfers on a rising edge where its valid and ready are both 1;
    // a raised valid and its payload hold steady until that transfer happens.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port synchronous RAM with write enable and a registered, enable-held read port.
module sp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read data only moves when i_re is pulsed, so it stays put for a held response.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// Sequential data memory for the core's load/store port: one outstanding request,
// WAIT_STATES cycles of latency, response held until the core accepts it.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic      osc_clk,
    input  logic      rst_n,
    mem_bus_if.slave  bus,
    output state_t    o_dbg_state
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          LSB  = $clog2(WORD_BYTES);
    localparam logic [3:0]  WS_L = 4'(WAIT_STATES);

    state_t          r_state;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic            r_load_ok;
    logic [3:0]      r_cnt;
    logic            r_write;
    logic            r_err;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_cur_write;
    logic            w_cur_err;
    logic [AW-1:0]   w_cur_idx;
    logic [31:0]     w_cur_wdata;
    logic            w_ram_we;
    logic            w_ram_re;
    logic [31:0]     w_ram_rdata;

    // In IDLE the live request feeds the RAM so a zero-wait access can commit on the accept edge.
    always_comb begin
        w_accept     = (r_state == IDLE) && bus.req_valid && r_req_ready;
        w_cur_write  = (r_state == IDLE) ? bus.req_write : r_write;
        w_cur_err    = (r_state == IDLE) ? addr_err(bus.req_addr, DEPTH_WORDS) : r_err;
        w_cur_idx    = (r_state == IDLE) ? bus.req_addr[LSB +: AW] : r_idx;
        w_cur_wdata  = (r_state == IDLE) ? bus.req_wdata : r_wdata;
        w_enter_resp = rst_n && ((w_accept && (WAIT_STATES == 0)) ||
                                 ((r_state == WAIT) && (r_cnt == WS_L)));
        w_ram_we     = w_enter_resp && w_cur_write && !w_cur_err;
        w_ram_re     = w_enter_resp && !w_cur_write && !w_cur_err;
    end

    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_ok    <= 1'b0;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_write     <= w_cur_write;
                        r_err       <= w_cur_err;
                        r_idx       <= w_cur_idx;
                        r_wdata     <= w_cur_wdata;
                        r_req_ready <= 1'b0;
                        r_cnt       <= 4'd1;
                        if (WAIT_STATES == 0) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_cur_err;
                            r_load_ok    <= !w_cur_write && !w_cur_err;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == WS_L) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_cur_err;
                        r_load_ok    <= !w_cur_write && !w_cur_err;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    // Ready rises with the consume edge so the next request lands one cycle later.
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_load_ok    <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    sp_ram #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (32)
    ) u_ram (
        .i_clk   (osc_clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_load_ok ? w_ram_rdata : 32'd0;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states, one with none,
// driven through a shared request port and checked against a word-array memory model.
module tb_data_mem_responder;
    import mem_if_pkg::*;

    localparam int DEPTH = 256;

    logic        osc_clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        o_req_ready;
    logic        o_resp_valid;
    logic        o_resp_err;
    logic [31:0] o_resp_rdata;
    state_t      o_state;
    state_t      dbg2;
    state_t      dbg0;

    int          tests_run;
    int          tests_failed;
    int          cyc;

    logic [31:0] ref_mem   [2][DEPTH];
    bit          ref_known [2][DEPTH];

    mem_bus_if b2 ();
    mem_bus_if b0 ();

    assign b2.req_valid  = req_valid && !sel;
    assign b0.req_valid  = req_valid && sel;
    assign b2.req_write  = req_write;
    assign b0.req_write  = req_write;
    assign b2.req_addr   = req_addr;
    assign b0.req_addr   = req_addr;
    assign b2.req_wdata  = req_wdata;
    assign b0.req_wdata  = req_wdata;
    assign b2.resp_ready = sel ? 1'b1 : resp_ready;
    assign b0.resp_ready = sel ? resp_ready : 1'b1;

    assign o_req_ready  = sel ? b0.req_ready  : b2.req_ready;
    assign o_resp_valid = sel ? b0.resp_valid : b2.resp_valid;
    assign o_resp_err   = sel ? b0.resp_err   : b2.resp_err;
    assign o_resp_rdata = sel ? b0.resp_rdata : b2.resp_rdata;
    assign o_state      = sel ? dbg0 : dbg2;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut2 (
        .osc_clk     (osc_clk),
        .rst_n       (rst_n),
        .bus         (b2.slave),
        .o_dbg_state (dbg2)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .osc_clk     (osc_clk),
        .rst_n       (rst_n),
        .bus         (b0.slave),
        .o_dbg_state (dbg0)
    );

    // clock / reset
    always #5 osc_clk = ~osc_clk;
    always @(posedge osc_clk) cyc = cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // driver: one full transaction on the selected instance, checked against the model
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int bp, input bit keep_valid, output int acc_cyc);
        int          k;
        int          d;
        int          idx;
        int          ws;
        bit          exp_err;
        bit          known;
        logic [31:0] exp_rd;
        logic [31:0] r0;
        logic        e0;
        d       = sel ? 1 : 0;
        ws      = sel ? 0 : 2;
        exp_err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        idx     = exp_err ? 0 : int'(addr / 4);
        known   = exp_err || ref_known[d][idx];
        exp_rd  = exp_err ? 32'd0 : ref_mem[d][idx];
        acc_cyc = cyc;

        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b0;
        k = 0;
        while (o_req_ready !== 1'b1 && k < 20) begin
            @(negedge osc_clk);
            k++;
        end
        if (o_req_ready !== 1'b1) begin
            check1("req_ready_timeout", o_req_ready, 1'b1);
            req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(negedge osc_clk);
        k = 1;
        if (!keep_valid) req_valid = 1'b0;
        while (o_resp_valid !== 1'b1 && k < 40) begin
            check1("req_ready_in_wait", o_req_ready, 1'b0);
            @(negedge osc_clk);
            k++;
        end
        check32("latency", k, ws + 1);
        if (o_resp_valid !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        check1("req_ready_in_resp", o_req_ready, 1'b0);
        r0 = o_resp_rdata;
        e0 = o_resp_err;
        check1("resp_err", e0, exp_err);
        if (wr) check32("store_rdata", r0, 32'd0);
        else if (known) check32("load_rdata", r0, exp_rd);
        for (int i = 0; i < bp; i++) begin
            @(negedge osc_clk);
            check1("bp_valid", o_resp_valid, 1'b1);
            check32("bp_rdata", o_resp_rdata, r0);
            check1("bp_err", o_resp_err, e0);
            check1("bp_req_ready", o_req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge osc_clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check1("resp_valid_drop", o_resp_valid, 1'b0);
        check1("req_ready_back", o_req_ready, 1'b1);
        if (wr && !exp_err) begin
            ref_mem[d][idx]   = wd;
            ref_known[d][idx] = 1'b1;
        end
    endtask

    initial begin
        int          a0;
        int          a1;
        int          k;
        int          r;
        logic [31:0] addr;
        logic [31:0] v;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        sel          = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b0;
        rst_n        = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) begin
                ref_known[d][i] = 1'b0;
                ref_mem[d][i]   = 32'd0;
            end

        // 1: reset values
        repeat (3) @(negedge osc_clk);
        check1("rst_req_ready", o_req_ready, 1'b0);
        check1("rst_resp_valid", o_resp_valid, 1'b0);
        check32("rst_resp_rdata", o_resp_rdata, 32'd0);
        check1("rst_resp_err", o_resp_err, 1'b0);
        check32("rst_state", 32'(o_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge osc_clk);
        check1("post_rst_req_ready", o_req_ready, 1'b1);

        // 2: store then load, two wait states
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, a0);
        do_txn(1'b0, 32'h10, 32'd0, 0, 1'b0, a0);

        // 3: error paths; word 0 must survive an out-of-range store
        do_txn(1'b1, 32'h0, 32'hA5A5_0001, 0, 1'b0, a0);
        do_txn(1'b0, 32'h13, 32'd0, 0, 1'b0, a0);
        do_txn(1'b1, 32'h400, 32'hBAD0_BAD0, 0, 1'b0, a0);
        do_txn(1'b0, 32'h0, 32'd0, 0, 1'b0, a0);
        do_txn(1'b1, 32'h3FC, 32'h7070_3FC0, 0, 1'b0, a0);
        do_txn(1'b0, 32'h3FC, 32'd0, 0, 1'b0, a0);
        do_txn(1'b0, 32'h400, 32'd0, 0, 1'b0, a0);

        // 4: backpressure with req_valid held high
        do_txn(1'b0, 32'h10, 32'd0, 5, 1'b1, a0);
        do_txn(1'b0, 32'h13, 32'd0, 5, 1'b1, a0);

        // 5a: reset in the first WAIT cycle drops an uncommitted store
        do_txn(1'b1, 32'h20, 32'h0BAD_F00D, 0, 1'b0, a0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234;
        @(negedge osc_clk);
        req_valid = 1'b0;
        check32("mid_state_wait", 32'(o_state), 32'(WAIT));
        rst_n = 1'b0;
        @(negedge osc_clk);
        check1("mid_rst_valid", o_resp_valid, 1'b0);
        check32("mid_rst_state", 32'(o_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge osc_clk);
        do_txn(1'b0, 32'h20, 32'd0, 0, 1'b0, a0);

        // 5b: reset while in RESP keeps a committed store
        v = $urandom;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h24;
        req_wdata = v;
        @(negedge osc_clk);
        req_valid = 1'b0;
        k = 0;
        while (o_resp_valid !== 1'b1 && k < 20) begin
            @(negedge osc_clk);
            k++;
        end
        check1("resp_before_rst", o_resp_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge osc_clk);
        check1("resp_rst_drop", o_resp_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge osc_clk);
        ref_mem[0][9]   = v;
        ref_known[0][9] = 1'b1;
        do_txn(1'b0, 32'h24, 32'd0, 0, 1'b0, a0);

        // 6: zero wait states, back-to-back loads of word 0 and the top word
        sel = 1'b1;
        @(negedge osc_clk);
        do_txn(1'b1, 32'h0, 32'h0000_AAAA, 0, 1'b0, a0);
        do_txn(1'b1, 32'h3FC, 32'h5555_0000, 0, 1'b0, a0);
        do_txn(1'b0, 32'h0, 32'd0, 0, 1'b0, a0);
        do_txn(1'b0, 32'h3FC, 32'd0, 0, 1'b0, a1);
        check32("ws0_accept_spacing", a1 - a0, 2);
        do_txn(1'b0, 32'h402, 32'd0, 0, 1'b0, a0);

        // randomized traffic against the model on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge osc_clk);
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r < 7)       addr = 32'($urandom_range(0, 15)) * 4;
                else if (r == 7) addr = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
                else if (r == 8) addr = 32'h3FC;
                else             addr = 32'h400 + 32'($urandom_range(0, 1023)) * 4;
                do_txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), a0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
